cacheline_adapter: RTL

- Sits between the unified cache-miss path (cache side, 256-bit lines) and physical memory (64-bit burst port) at the top level.
- Converts one line read into a 4-beat burst read and assembles the line.
- Converts one line write into a 4-beat burst write.
- Presents a single-cycle response handshake back to the cache side.

---
 rtl/cacheline_adapter.sv | 104 ++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache line to 4-beat 64-bit memory burst adapter
module cacheline_adapter #(
   parameter int LINE_WIDTH  = 256,
   parameter int BURST_WIDTH = 64,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   line_read_i,
   input  logic                   line_write_i,
   input  logic [ADDR_WIDTH-1:0]  line_address_i,
   input  logic [LINE_WIDTH-1:0]  line_wdata_i,
   output logic [LINE_WIDTH-1:0]  line_rdata_o,
   output logic                   line_resp_o,
   input  logic [BURST_WIDTH-1:0] burst_rdata_i,
   input  logic                   burst_resp_i,
   output logic                   burst_read_o,
   output logic                   burst_write_o,
   output logic [ADDR_WIDTH-1:0]  burst_address_o,
   output logic [BURST_WIDTH-1:0] burst_wdata_o
);
   localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
   localparam int BEAT_W   = $clog2(BEATS);
   localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                state;
   logic [BEAT_W-1:0]     beat;
   logic [BEAT_W-1:0]     next_beat;
   logic [LINE_WIDTH-1:0] wline;
   logic [LINE_WIDTH-1:0] rline;
   logic [LINE_WIDTH-1:0] rline_next;

   // Read line with the current beat merged in, so the final beat can be
   // published to line_rdata_o on the same edge it arrives.
   always_comb begin
      next_beat  = beat + 1'b1;
      rline_next = rline;
      rline_next[int'(beat)*BURST_WIDTH +: BURST_WIDTH] = burst_rdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         beat            <= '0;
         wline           <= '0;
         rline           <= '0;
         line_rdata_o    <= '0;
         line_resp_o     <= 1'b0;
         burst_read_o    <= 1'b0;
         burst_write_o   <= 1'b0;
         burst_address_o <= '0;
         burst_wdata_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat <= '0;
               if (line_write_i) begin
                  burst_address_o <= {line_address_i[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
                  wline           <= line_wdata_i;
                  burst_wdata_o   <= line_wdata_i[BURST_WIDTH-1:0];
                  burst_write_o   <= 1'b1;
                  state           <= WRITE;
               end else if (line_read_i) begin
                  burst_address_o <= {line_address_i[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
                  burst_read_o    <= 1'b1;
                  state           <= READ;
               end
            end
            READ: begin
               if (burst_resp_i) begin
                  rline <= rline_next;
                  beat  <= next_beat;
                  if (beat == LAST_BEAT) begin
                     line_rdata_o <= rline_next;
                     line_resp_o  <= 1'b1;
                     burst_read_o <= 1'b0;
                     state        <= DONE;
                  end
               end
            end
            WRITE: begin
               if (burst_resp_i) begin
                  beat <= next_beat;
                  if (beat == LAST_BEAT) begin
                     line_resp_o   <= 1'b1;
                     burst_write_o <= 1'b0;
                     state         <= DONE;
                  end else begin
                     burst_wdata_o <= wline[int'(next_beat)*BURST_WIDTH +: BURST_WIDTH];
                  end
               end
            end
            DONE: begin
               line_resp_o <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
